// File: rtl/echo_delay_ctrl.sv
// Echo/delay engine: per-sample read-modify-write of a circular delay line in external memory.
// Optional power-up memory clear is enabled by defining ECHO_MEM_CLEAR_EN.
module echo_delay_ctrl #(
    parameter int DATALEN = 16,
    parameter int MEMLEN  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_valid,
    input  logic signed [DATALEN-1:0] sample_in,
    input  logic [MEMLEN-1:0]         delay,
    input  logic [7:0]                feedback,
    output logic signed [DATALEN-1:0] sample_out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun,
    output logic [MEMLEN-1:0]         mem_addr,
    output logic [DATALEN-1:0]        mem_datain,
    output logic                      mem_wren,
    input  logic [DATALEN-1:0]        mem_dataout
);

`ifdef ECHO_MEM_CLEAR_EN
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_RD = 3'd1, S_WT = 3'd2, S_WR = 3'd3, S_CLR = 3'd4} state_e;
    localparam state_e RESET_STATE = S_CLR;
    localparam logic [MEMLEN:0] CLR_LAST = {1'b1, {MEMLEN{1'b0}}};
    logic [MEMLEN:0] clr_cnt_q, clr_cnt_d;
`else
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_RD = 3'd1, S_WT = 3'd2, S_WR = 3'd3} state_e;
    localparam state_e RESET_STATE = S_IDLE;
`endif

    state_e                     state_q, state_d;
    logic [MEMLEN-1:0]          wr_ptr_q, wr_ptr_d;
    logic signed [DATALEN-1:0]  in_q, in_d;
    logic [7:0]                 fb_q, fb_d;
    logic                       dzero_q, dzero_d;
    logic signed [DATALEN-1:0]  sample_out_q, sample_out_d;
    logic                       out_valid_q, out_valid_d;
    logic                       overrun_q, overrun_d;
    logic [MEMLEN-1:0]          mem_addr_q, mem_addr_d;
    logic [DATALEN-1:0]         mem_datain_q, mem_datain_d;
    logic                       mem_wren_q, mem_wren_d;

    logic signed [DATALEN-1:0]  d_s;
    logic signed [DATALEN+8:0]  prod_s;
    logic signed [DATALEN+8:0]  scaled_s;
    logic signed [DATALEN+1:0]  out_sum_s;
    logic signed [DATALEN+1:0]  wb_sum_s;

    // Clamp a two-bit-headroom sum back into the DATALEN signed range.
    function automatic logic signed [DATALEN-1:0] sat(input logic signed [DATALEN+1:0] v);
        if ((v[DATALEN+1:DATALEN-1] == 3'b000) || (v[DATALEN+1:DATALEN-1] == 3'b111)) begin
            return v[DATALEN-1:0];
        end else if (v[DATALEN+1]) begin
            return {1'b1, {(DATALEN-1){1'b0}}};
        end else begin
            return {1'b0, {(DATALEN-1){1'b1}}};
        end
    endfunction

    // Mix datapath: delayed sample scaled by feedback/256 with floor rounding.
    always_comb begin
        d_s       = dzero_q ? '0 : $signed(mem_dataout);
        prod_s    = $signed({{9{d_s[DATALEN-1]}}, d_s}) * $signed({{(DATALEN+1){1'b0}}, fb_q});
        scaled_s  = prod_s >>> 4'd8;
        out_sum_s = $signed({{2{in_q[DATALEN-1]}}, in_q}) + $signed({{2{d_s[DATALEN-1]}}, d_s});
        wb_sum_s  = $signed({{2{in_q[DATALEN-1]}}, in_q}) + scaled_s[DATALEN+1:0];
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            wr_ptr_q     <= '0;
            in_q         <= '0;
            fb_q         <= 8'd0;
            dzero_q      <= 1'b0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_datain_q <= '0;
            mem_wren_q   <= 1'b0;
`ifdef ECHO_MEM_CLEAR_EN
            clr_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            in_q         <= in_d;
            fb_q         <= fb_d;
            dzero_q      <= dzero_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            mem_addr_q   <= mem_addr_d;
            mem_datain_q <= mem_datain_d;
            mem_wren_q   <= mem_wren_d;
`ifdef ECHO_MEM_CLEAR_EN
            clr_cnt_q    <= clr_cnt_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD:    state_d = S_WT;
            S_WT:    state_d = S_WR;
            S_WR:    state_d = S_IDLE;
`ifdef ECHO_MEM_CLEAR_EN
            S_CLR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CLR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; outputs are registered so they line up with the next state.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        in_d         = in_q;
        fb_d         = fb_q;
        dzero_d      = dzero_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        overrun_d    = sample_valid && (state_q != S_IDLE);
        mem_addr_d   = mem_addr_q;
        mem_datain_d = mem_datain_q;
        mem_wren_d   = 1'b0;
`ifdef ECHO_MEM_CLEAR_EN
        clr_cnt_d    = clr_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    in_d       = sample_in;
                    fb_d       = feedback;
                    dzero_d    = (delay == '0);
                    mem_addr_d = wr_ptr_q - delay;
                end else begin
                    in_d       = in_q;
                end
            end
            S_RD: begin
                mem_wren_d = 1'b0;
            end
            S_WT: begin
                sample_out_d = sat(out_sum_s);
                mem_datain_d = sat(wb_sum_s);
                mem_addr_d   = wr_ptr_q;
                mem_wren_d   = 1'b1;
                out_valid_d  = 1'b1;
            end
            S_WR: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
`ifdef ECHO_MEM_CLEAR_EN
            // Writes lag the counter by one cycle; the final CLR cycle carries the last write.
            S_CLR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q != CLR_LAST) begin
                    mem_wren_d   = 1'b1;
                    mem_addr_d   = clr_cnt_q[MEMLEN-1:0];
                    mem_datain_d = '0;
                end else begin
                    mem_wren_d   = 1'b0;
                end
            end
`endif
            default: begin
                mem_wren_d = 1'b0;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign mem_addr   = mem_addr_q;
    assign mem_datain = mem_datain_q;
    assign mem_wren   = mem_wren_q;

endmodule

// File: doc/echo_delay_ctrl.md
ECHO_DELAY_CTRL -- requirements
Module: echo_delay_ctrl

Interface
REQ-001 SHALL have parameter DATALEN, default 16, audio sample and memory data width.
REQ-002 SHALL have parameter MEMLEN, default 16, memory word address width (65536 words).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sample_valid  input  1  one-cycle strobe, new input sample present.
REQ-006 sample_in  input  DATALEN  signed two's-complement input sample.
REQ-007 delay  input  MEMLEN  echo delay in samples, sampled on accepted sample_valid.
REQ-008 feedback  input  8  unsigned feedback gain, value/256, sampled on accepted sample_valid.
REQ-009 sample_out  output  DATALEN  signed dry+echo output sample.
REQ-010 out_valid  output  1  one-cycle strobe, sample_out updated.
REQ-011 busy  output  1  high whenever FSM not in IDLE.
REQ-012 overrun  output  1  one-cycle pulse, sample_valid dropped.
REQ-013 mem_addr  output  MEMLEN  word address to downstream single-port memory.
REQ-014 mem_datain  output  DATALEN  write data to memory.
REQ-015 mem_wren  output  1  memory write enable, high only in WR/CLR.
REQ-016 mem_dataout  input  DATALEN  memory read data, valid one cycle after address presented.

Function
REQ-017 FSM states: IDLE, RD, WT, WR (plus CLR under configuration); IDLE->RD on sample_valid, RD->WT, WT->WR, WR->IDLE unconditionally.
REQ-018 On accept (IDLE, sample_valid=1): latch sample_in, delay, feedback.
REQ-019 RD: mem_addr = wr_ptr - delay_latched modulo 2^MEMLEN, mem_wren=0.
REQ-020 WT: capture mem_dataout as d; compute out = sat16(in + d) and wb = sat16(in + ((d * feedback) >>> 8)); product 24-bit signed, arithmetic shift.
REQ-021 Saturation: clamp to [-32768, 32767], never wrap.
REQ-022 delay_latched = 0: d forced to 0, so out = in, wb = in.
REQ-023 WR: mem_addr = wr_ptr, mem_datain = wb, mem_wren=1, out_valid=1, sample_out = out; wr_ptr increments on exit, wrapping 65535->0.
REQ-024 Latency: sample_valid in cycle N -> out_valid in cycle N+3; back in IDLE at N+4; minimum sample spacing 4 cycles.
REQ-025 sample_valid while busy=1: sample ignored, no state change, overrun pulses next cycle.
REQ-026 sample_out holds last value between out_valid strobes.
REQ-027 Outside RD/WR/CLR: mem_wren=0, mem_addr holds last value.

Reset
REQ-028 Reset asserted in any state: FSM to IDLE (or CLR when configured), wr_ptr=0, sample_out=0, out_valid=0, overrun=0, mem_wren=0, mem_addr=0, mem_datain=0, in-flight sample discarded without memory write.

Configuration
REQ-029 Macro ECHO_MEM_CLEAR_EN defined: after reset release FSM enters CLR, writes 0 to addresses 0..65535 one per cycle (mem_wren=1), busy=1, sample_valid ignored with overrun; then IDLE with wr_ptr=0.
REQ-030 ECHO_MEM_CLEAR_EN undefined: no CLR state; FSM enters IDLE after reset, memory contents undefined.

Verification
REQ-031 Reset, sample_in=1000, delay=0, feedback=128 -> out_valid 3 cycles later, sample_out=1000, write 1000 at addr 0.
REQ-032 Memory model preloaded addr 65535 with 2000, wr_ptr=0, delay=1, feedback=128, sample_in=500 -> RD addr 65535, sample_out=2500, write 1500 at addr 0.
REQ-033 d=30000, sample_in=10000, feedback=255 -> sample_out=32767, wb=32767 (saturated); d=-30000, sample_in=-10000 -> -32768.
REQ-034 Second sample_valid 2 cycles after first -> overrun pulse, exactly one out_valid, one memory write.
REQ-035 Reset asserted during WT -> no mem_wren, no out_valid, outputs zero; with ECHO_MEM_CLEAR_EN, 65536 zero writes then busy=0.
